rv32i_iter_alu: RTL and testbench
=================================

Name: rv32i_iter_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, plus two operands, and returns a result.
- Non-shift ops complete in one cycle. Shifts run iteratively, one bit per cycle, to save area on the Cyclone V.
- Valid/ready handshakes on both sides let the multi-cycle core stall the pipeline.

Parameters:
- XLEN, 32, operand/result width. Shift amount width is log2(XLEN) = 5 at the default.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- alu_ctrl  in  4  {func7[5], func3} code: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B; shift amount is op_b[4:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0, registered with result (branch compare)
- illegal  out  1  alu_ctrl not in the table above

Behaviour:
- Reset: async on rst_n low.
  - State = IDLE; in_ready=1; out_valid=0; result=0; zero=0; illegal=0; shift counter=0.
  - Reset mid-operation abandons the operation; no output is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op_a, op_b and alu_ctrl.
  - Non-shift or illegal op: compute, register result/zero/illegal, go to DONE.
  - Shift op with shamt!=0: load the working register with op_a and counter with shamt, go to SHIFT.
  - Shift op with shamt==0: result=op_a, go to DONE.
- SHIFT:
  - in_ready=0.
  - Each cycle: working register shifts by 1 (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill) and the counter decrements.
  - When the counter reaches 1 on the current shift, go to DONE with the final value.
- DONE:
  - out_valid=1; in_ready=0.
  - result, zero and illegal are held stable until out_ready=1.
  - The handshake completes in the cycle out_valid and out_ready are both 1. Next state is IDLE, out_valid drops next cycle.
- Latency (accept edge to out_valid): 1 cycle for non-shift and shamt=0; 1+shamt cycles for shifts (max 32).
- No overlap: a new request is not accepted until back in IDLE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN; no carry/overflow output.
  - SLT is signed compare, SLTU unsigned. Both give 1 or 0 in bit 0, upper bits 0.
- Illegal code: result=0, zero=1, illegal=1, latency 1. The block does not hang.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Inputs are sampled only on the accept edge. Changes to op_a, op_b or alu_ctrl during SHIFT or DONE have no effect.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN
- Defined: shifts use a single-cycle barrel shifter. SHIFT state and counter are not built. All ops have latency 1.
- Undefined: iterative shifter as above, latency 1+shamt.
- Handshake and all other behaviour are identical in both builds.

Test Plan:
- Reset asserted while in SHIFT (SLL, shamt=20, 5 cycles in) -> out_valid=0 and in_ready=1 immediately. After release, ADD 1+1 -> result=2 after 1 cycle.
- ADD 0xFFFFFFFF+1 -> result=0, zero=1, latency 1; SUB 5-7 -> 0xFFFFFFFE, zero=0.
- SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; AND/OR/XOR 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
- Shifts (iterative build):
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF, out_valid 32 cycles after accept.
  - SRL same -> 0x00000001.
  - SLL 0x1 by 0 -> 0x1, latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one transfer, then IDLE.
- Illegal alu_ctrl=1111 -> illegal=1, result=0, latency 1. Repeat the shift tests with ALU_FAST_SHIFT_EN -> same values, latency 1.

Source files
------------

// File: rtl/rv32i_iter_alu_if.sv
// Request/response bundle for rv32i_iter_alu: valid/ready in, registered result out.
interface rv32i_iter_alu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/rv32i_iter_alu.sv
// RV32I execute ALU; shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN
// selects a single-cycle barrel shifter. All other ops complete in one cycle.
module rv32i_iter_alu #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst_n,
  rv32i_iter_alu_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b0001;
  localparam logic [3:0] C_SLT  = 4'b0010;
  localparam logic [3:0] C_SLTU = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SRA  = 4'b1101;
  localparam logic [3:0] C_OR   = 4'b0110;
  localparam logic [3:0] C_AND  = 4'b0111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            ill_q, ill_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [SHW-1:0]  shamt;

  assign shamt = bus.op_b[SHW-1:0];

`ifndef ALU_FAST_SHIFT_EN
  // res_q doubles as the shift working register while in SHIFT
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            sh_left_q, sh_left_d;
  logic            sh_arith_q, sh_arith_d;
  logic            is_shift;
  logic [XLEN-1:0] sh_step;

  assign is_shift = (bus.alu_ctrl == C_SLL) || (bus.alu_ctrl == C_SRL) ||
                    (bus.alu_ctrl == C_SRA);
  assign sh_step  = sh_left_q ? {res_q[XLEN-2:0], 1'b0}
                              : {(sh_arith_q & res_q[XLEN-1]), res_q[XLEN-1:1]};
`endif

  // Single-cycle result for the request presented in IDLE
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.alu_ctrl)
      C_ADD:  alu_res = bus.op_a + bus.op_b;
      C_SUB:  alu_res = bus.op_a - bus.op_b;
      C_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      C_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      C_XOR:  alu_res = bus.op_a ^ bus.op_b;
      C_OR:   alu_res = bus.op_a | bus.op_b;
      C_AND:  alu_res = bus.op_a & bus.op_b;
`ifdef ALU_FAST_SHIFT_EN
      C_SLL:  alu_res = bus.op_a << shamt;
      C_SRL:  alu_res = bus.op_a >> shamt;
      C_SRA:  alu_res = $unsigned($signed(bus.op_a) >>> shamt);
`else
      C_SLL, C_SRL, C_SRA: alu_res = bus.op_a;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ill_q      <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q      <= '0;
      sh_left_q  <= 1'b0;
      sh_arith_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      ill_q      <= ill_d;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q      <= cnt_d;
      sh_left_q  <= sh_left_d;
      sh_arith_q <= sh_arith_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    zero_d     = zero_q;
    ill_d      = ill_q;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d      = cnt_q;
    sh_left_d  = sh_left_q;
    sh_arith_d = sh_arith_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          res_d   = alu_res;
          zero_d  = (alu_res == '0);
          ill_d   = alu_ill;
          state_d = S_DONE;
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift && (shamt != '0)) begin
            state_d    = S_SHIFT;
            cnt_d      = shamt;
            sh_left_d  = (bus.alu_ctrl == C_SLL);
            sh_arith_d = (bus.alu_ctrl == C_SRA);
          end
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        res_d = sh_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
          zero_d  = (sh_step == '0);
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.result    = res_q;
    bus.zero      = zero_q;
    bus.illegal   = ill_q;
  end
endmodule

// File: tb/tb_rv32i_iter_alu.sv
// Randomized + directed bench for rv32i_iter_alu against a plain-arithmetic reference.
module tb_rv32i_iter_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rv32i_iter_alu_if #(.XLEN(32)) bus ();
  rv32i_iter_alu #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (c)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b0001: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: r = $unsigned($signed(a) >>> sh);
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
`ifndef ALU_FAST_SHIFT_EN
    if (c == 4'b0001 || c == 4'b0101 || c == 4'b1101) lat = 1 + sh;
`endif
  endfunction

  task automatic junk_inputs();
    bus.alu_ctrl = 4'($urandom);
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ei;
    int          elat, lat;
    ref_alu(c, a, b, er, ei, elat);
    @(negedge clk);
    chk($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
    bus.alu_ctrl = c; bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    junk_inputs();
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (lat % 7 == 0) junk_inputs();
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(elat));
    chk($sformatf("%s result", tag), bus.result, er);
    chk($sformatf("%s zero", tag), 32'(bus.zero), 32'(er == 32'd0));
    chk($sformatf("%s illegal", tag), 32'(bus.illegal), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      junk_inputs();
      @(posedge clk); #1;
      chk($sformatf("%s hold result", tag), bus.result, er);
      chk($sformatf("%s hold valid", tag), 32'(bus.out_valid), 32'd1);
      chk($sformatf("%s hold in_ready", tag), 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk($sformatf("%s drop valid", tag), 32'(bus.out_valid), 32'd0);
    chk($sformatf("%s back idle", tag), 32'(bus.in_ready), 32'd1);
  endtask

  logic [3:0] legal [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                             4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_ctrl = '0; bus.op_a = '0; bus.op_b = '0;
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", bus.result, 32'd0);
    chk("rst zero", 32'(bus.zero), 32'd0);
    chk("rst illegal", 32'(bus.illegal), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a long shift abandons it
    @(negedge clk);
    bus.alu_ctrl = 4'b0001; bus.op_a = 32'd1; bus.op_b = 32'd20; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add1+1", 4'b0000, 32'd1, 32'd1, 0);

    run_op("add wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub", 4'b1000, 32'd5, 32'd7, 1);
    run_op("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op("or", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op("sra31", 4'b1101, 32'h8000_0000, 32'd31, 0);
    run_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 0);
    run_op("sll0", 4'b0001, 32'd1, 32'd0, 0);
    run_op("sll to zero", 4'b0001, 32'h8000_0000, 32'd1, 0);
    run_op("backpressure", 4'b0000, 32'd100, 32'd23, 10);
    run_op("illegal", 4'b1111, 32'd3, 32'd4, 2);

    for (int i = 0; i < 150; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal[$urandom_range(0, 9)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 32'd0;
      run_op($sformatf("rnd%0d c=%b", i, c), c, a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
